// File: rtl/md_seq_pkg.sv
// md_seq_pkg -- shared definitions for the HI/LO multiply/divide sequencer.
//   md_op_e    : operation codes presented on md_seq.op / md_arith.op
//   md_state_e : sequencer FSM states
//   MUL_CYCLES : busy latency of MULT/MULTU/MADD/MADDU
//   DIV_CYCLES : busy latency of DIV/DIVU
// Optional feature macro: MD_SEQ_MADD_EN (enables MADD/MADDU).
package md_seq_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MUL_CYCLES = 5;
    localparam int unsigned DIV_CYCLES = 10;
    localparam int          CNT_W      = 4;

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_move(input logic [2:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith -- combinational product/quotient unit for md_seq.
// Ports:
//   op     in  3   operation code (md_op_e)
//   a      in  32  rs operand (multiplicand / dividend)
//   b      in  32  rt operand (multiplier / divisor)
//   hi, lo in  32  current architectural HI/LO
//   result out 64  {hi,lo} value to commit when the operation completes
// Optional feature macro: MD_SEQ_MADD_EN (adds the {hi,lo} accumulate adder).
module md_arith
    import md_seq_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic signed [63:0] a_s64;
    logic signed [63:0] b_s64;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [63:0] quot_s;
    logic signed [63:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               div_zero;
    logic               unused_upper;

    // Signed divide is done at 64 bits so that -2^31 / -1 wraps cleanly
    // instead of hitting a 32-bit overflow corner.
    assign a_s64    = {{32{a[31]}}, a};
    assign b_s64    = {{32{b[31]}}, b};
    assign div_zero = (b == 32'd0);

    assign prod_s = a_s64 * b_s64;
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign quot_s = div_zero ? 64'sd0 : (a_s64 / b_s64);
    assign rem_s  = div_zero ? 64'sd0 : (a_s64 % b_s64);
    assign quot_u = div_zero ? 32'd0  : (a / b);
    assign rem_u  = div_zero ? 32'd0  : (a % b);

    assign unused_upper = ^{quot_s[63:32], rem_s[63:32]};

`ifdef MD_SEQ_MADD_EN
    logic [63:0] acc_in;
    logic [63:0] acc_sum;

    assign acc_in  = (op == OP_MADD) ? prod_s : prod_u;
    assign acc_sum = {hi, lo} + acc_in;
`endif

    always_comb begin
        result = {hi, lo};
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            // Divide by zero recommits the current HI/LO, leaving them unchanged.
            OP_DIV:   result = div_zero ? {hi, lo} : {rem_s[31:0], quot_s[31:0]};
            OP_DIVU:  result = div_zero ? {hi, lo} : {rem_u, quot_u};
`ifdef MD_SEQ_MADD_EN
            OP_MADD:  result = acc_sum;
            OP_MADDU: result = acc_sum;
`endif
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/md_seq.sv
// md_seq -- multi-cycle multiply/divide sequencer owning HI/LO.
// Ports:
//   clk    in  1   clock, rising edge
//   reset  in  1   asynchronous active-high reset
//   start  in  1   launch request for op
//   op     in  3   operation code (md_op_e)
//   a, b   in  32  rs / rt operands
//   req    in  1   CP0 exception/interrupt request; squashes a same-cycle start
//   busy   out 1   multiply/divide in flight
//   hi, lo out 32  architectural HI/LO
// Optional feature macro: MD_SEQ_MADD_EN (MADD/MADDU accepted; otherwise ignored).
module md_seq
    import md_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e         state;
    md_state_e         state_next;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       pending;
    logic [63:0]       arith_res;
    logic              op_valid;
    logic              accept;
    logic              launch;
    logic              commit;

    md_arith u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (hi),
        .lo     (lo),
        .result (arith_res)
    );

    always_comb begin
`ifdef MD_SEQ_MADD_EN
        op_valid = 1'b1;
`else
        op_valid = !((op == OP_MADD) || (op == OP_MADDU));
`endif
    end

    assign busy   = (state == ST_RUN);
    assign accept = start && !busy && !req && op_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Commit happens on the edge that takes the counter from 1 to 0.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && !op_is_move(op)) begin
                    launch     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt <= CNT_W'(1)) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            pending <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (accept && (op == OP_MTHI)) begin
                hi <= a;
            end else if (accept && (op == OP_MTLO)) begin
                lo <= a;
            end else if (launch) begin
                pending <= arith_res;
                cnt     <= op_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
                if (commit) begin
                    {hi, lo} <= pending;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq -- self-checking bench for md_seq: directed cases plus randomized
// traffic compared against a transaction-level reference model.
// Optional feature macro: MD_SEQ_MADD_EN (must match the RTL build).
module tb_md_seq;
    import md_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;
    int busy_cycles = 0;

    // Reference model state: architectural HI/LO, remaining busy cycles,
    // and the result waiting to land when the countdown ends.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_rem;
    logic [63:0] m_pend;
    bit          m_pend_we;

`ifdef MD_SEQ_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    md_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .req   (req),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] x,
                                                 input logic [31:0] y, input logic [31:0] h,
                                                 input logic [31:0] l, output bit we);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] res;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        we  = 1'b1;
        res = {h, l};
        case (o)
            3'd0: res = sx * sy;
            3'd1: res = ux * uy;
            3'd2: begin
                if (y == 32'd0) begin
                    we = 1'b0;
                end else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (y == 32'd0) we = 1'b0;
                else            res = {x % y, x / y};
            end
            3'd6: res = {h, l} + (sx * sy);
            3'd7: res = {h, l} + (ux * uy);
            default: we = 1'b0;
        endcase
        return res;
    endfunction

    task automatic model_reset();
        m_hi      = '0;
        m_lo      = '0;
        m_rem     = 0;
        m_pend    = '0;
        m_pend_we = 1'b0;
    endtask

    // Advance the model by one clock edge given the inputs presented to it.
    task automatic model_step(input bit st, input logic [2:0] o, input logic [31:0] x,
                              input logic [31:0] y, input bit rq);
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pend_we) {m_hi, m_lo} = m_pend;
        end else if (st && !rq && (o < 3'd6 || MADD_ON)) begin
            if (o == 3'd4) begin
                m_hi = x;
            end else if (o == 3'd5) begin
                m_lo = x;
            end else begin
                m_pend = model_result(o, x, y, m_hi, m_lo, m_pend_we);
                m_rem  = (o == 3'd2 || o == 3'd3) ? int'(DIV_CYCLES) : int'(MUL_CYCLES);
            end
        end
    endtask

    task automatic step(input bit st, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit rq);
        @(negedge clk);
        start = st;
        op    = o;
        a     = x;
        b     = y;
        req   = rq;
        model_step(st, o, x, y, rq);
        @(posedge clk);
        #1;
        check("busy", {63'd0, busy}, {63'd0, (m_rem > 0)});
        check("hi", {32'd0, hi}, {32'd0, m_hi});
        check("lo", {32'd0, lo}, {32'd0, m_lo});
        if (busy) busy_cycles++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        req   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // MULT -2 * 3
        busy_cycles = 0;
        step(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(6);
        check("mult_busy_len", 64'(busy_cycles), 64'd5);
        check("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        check("mult_lo", {32'd0, lo}, 64'hFFFF_FFFA);

        // DIV -7 / 2
        busy_cycles = 0;
        step(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(11);
        check("div_busy_len", 64'(busy_cycles), 64'd10);
        check("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);

        // DIVU 7 / 0 leaves HI/LO alone
        busy_cycles = 0;
        step(1'b1, OP_DIVU, 32'd7, 32'd0, 1'b0);
        idle(11);
        check("div0_busy_len", 64'(busy_cycles), 64'd10);
        check("div0_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div0_hi", {32'd0, hi}, 64'hFFFF_FFFF);

        // Same-cycle req squashes start
        busy_cycles = 0;
        step(1'b1, OP_MULT, 32'd5, 32'd6, 1'b1);
        idle(2);
        check("req_mult_busy", 64'(busy_cycles), 64'd0);
        check("req_mult_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        step(1'b1, OP_MTHI, 32'h0000_1234, 32'd0, 1'b1);
        check("req_mthi_hi", {32'd0, hi}, 64'hFFFF_FFFF);

        // Overlap: start while busy ignored; start on first idle cycle accepted
        step(1'b1, OP_MULTU, 32'd10, 32'd20, 1'b0);
        step(1'b1, OP_DIVU, 32'd100, 32'd3, 1'b0);
        idle(4);
        check("ovl_busy", {63'd0, busy}, 64'd0);
        check("ovl_lo", {32'd0, lo}, 64'd200);
        check("ovl_hi", {32'd0, hi}, 64'd0);
        step(1'b1, OP_MULT, 32'd7, 32'd7, 1'b0);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        idle(5);
        check("b2b_lo", {32'd0, lo}, 64'd49);

        // Asynchronous reset in the middle of a DIV
        step(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
        step(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
        idle(2);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_hi", {32'd0, hi}, 64'd0);
        check("rst_mid_lo", {32'd0, lo}, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, OP_MTLO, 32'hA5A5_A5A5, 32'd0, 1'b0);
        check("post_rst_mtlo", {32'd0, lo}, 64'hA5A5_A5A5);

        // MADDU accumulate (or ignored when not compiled in)
        step(1'b1, OP_MTHI, 32'd0, 32'd0, 1'b0);
        step(1'b1, OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
        busy_cycles = 0;
        step(1'b1, OP_MADDU, 32'd1, 32'd1, 1'b0);
        idle(6);
        check("maddu_busy_len", 64'(busy_cycles), MADD_ON ? 64'd5 : 64'd0);
        check("maddu_hi", {32'd0, hi}, MADD_ON ? 64'd1 : 64'd0);
        check("maddu_lo", {32'd0, lo}, MADD_ON ? 64'd0 : 64'hFFFF_FFFF);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            int          sel;
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      rb = 32'd0;
            else if (sel == 1) rb = $urandom_range(1, 9);
            else if (sel == 2) rb = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            step(($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), ra, rb,
                 ($urandom_range(0, 4) == 0));
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 md_seq SHALL have no parameters; latencies come from package constants MUL_CYCLES = 5 and DIV_CYCLES = 10.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to launch the operation on op, sampled at a rising edge.
REQ-005 op  input  3  operation code from the package: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU.
REQ-006 a  input  32  operand rs (dividend, multiplicand, or MTHI/MTLO source).
REQ-007 b  input  32  operand rt (divisor or multiplier).
REQ-008 req  input  1  exception/interrupt request from CP0; suppresses the instruction currently presenting start.
REQ-009 busy  output  1  high while an accepted multiply/divide is in flight.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.

Function
REQ-012 The FSM SHALL have exactly the states IDLE and RUN.
REQ-013 Acceptance: start=1, busy=0, req=0 and a valid op at an edge SHALL count as accepted; anything else SHALL be ignored with no state change.
REQ-014 start with req=1 SHALL be ignored entirely, including MTHI/MTLO.
REQ-015 start while busy=1 SHALL be ignored; the in-flight operation SHALL continue unaffected.
REQ-016 MTHI/MTLO accepted SHALL write a into hi/lo at that edge; FSM stays IDLE; busy stays 0.
REQ-017 MULT/MULTU/MADD/MADDU accepted SHALL load counter = MUL_CYCLES, enter RUN, and assert busy from the next cycle.
REQ-018 DIV/DIVU accepted SHALL load counter = DIV_CYCLES and behave the same way.
REQ-019 The result SHALL be computed from a/b as sampled at the accept edge and held in internal pending registers; hi/lo SHALL NOT change while in RUN.
REQ-020 In RUN, counter SHALL decrement each edge; at the edge where it reaches 0, pending SHALL commit to hi/lo, FSM SHALL return to IDLE and busy SHALL fall.
REQ-021 busy SHALL be high for exactly N cycles for latency N; a new start is acceptable in the first cycle busy=0.
REQ-022 req during RUN SHALL NOT cancel or restart the operation.
REQ-023 MULT: {hi,lo} SHALL be the signed 64-bit product. MULTU: the unsigned 64-bit product.
REQ-024 DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-025 DIVU: lo and hi SHALL be the unsigned quotient and remainder.
REQ-026 Divide by zero (b=0) SHALL still run DIV_CYCLES with busy high, then leave hi/lo unchanged.
REQ-027 MADD/MADDU (when compiled in) SHALL commit {hi,lo} + product, using {hi,lo} as held at the accept edge, with 64-bit wrap-around and no overflow flag.
REQ-028 An undefined op code SHALL be ignored as not accepted.

Reset
REQ-029 Asserting reset at any time, including mid-RUN, SHALL immediately force: FSM to IDLE, counter to 0, busy to 0, hi/lo to 0, pending registers to 0.
REQ-030 The first acceptable start SHALL be the first rising edge with reset low.

Configuration
REQ-031 With macro MD_SEQ_MADD_EN defined, MADD and MADDU SHALL be implemented as in REQ-027.
REQ-032 Without MD_SEQ_MADD_EN, MADD and MADDU SHALL be treated as undefined ops (REQ-028), and the accumulate adder SHALL be absent.

Structure
REQ-033 Op encodings, MUL_CYCLES and DIV_CYCLES SHALL live in the shared package or header used by the control decoder.
REQ-034 The FSM, counter and hi/lo SHALL be in md_seq.
REQ-035 The product/quotient arithmetic SHALL be one combinational sub-module, md_arith, taking op, a, b, hi, lo and returning the 64-bit pending result.

Verification
REQ-036 MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-037 DIV a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> busy high 10 cycles; hi/lo unchanged.
REQ-038 Same-cycle req: start with MULT plus req=1 -> busy stays 0, hi/lo unchanged. MTHI 0x1234 plus req=1 -> hi unchanged.
REQ-039 Back-to-back and overlap: a second start while busy -> ignored, with the first result as specified. A start on the first cycle busy=0 -> accepted.
REQ-040 Reset on cycle 3 of a DIV -> busy=0 and hi=lo=0 immediately. A subsequent MTLO 0xA5A5A5A5 -> lo=0xA5A5A5A5 at the next edge.
REQ-041 With MD_SEQ_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0. Without the macro: same stimulus -> busy stays 0, hi/lo unchanged.
